// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial converter feeding the three-ones run
// detector's serial input. Words are taken over a valid/ready handshake and
// shifted out one bit per clock, MSB- or LSB-first. Back-to-back words stream
// with no gap. Between words the line sits at IDLE_LEVEL.
//
// Optional build macro: SER_PARITY_EN appends an even-parity bit to each
// frame, so the frame becomes WIDTH+1 bits long.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no frame in flight; ready for a word; line at IDLE_LEVEL
// SHIFT | presenting bit 'cnt' of the current frame on x_out
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    cnt, cnt_d, cnt_inc;
  logic             x_out_d, x_valid_d, busy_d, frame_done_d;
  logic             last_bit, accept;
  logic             load_first, next_bit;
  logic [WIDTH-1:0] load_rest, shreg_shift;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Shift direction selects which end of the word leaves first; after a load
  // the register already holds the remaining bits aligned to that end.
  always_comb begin
    if (MSB_FIRST) begin
      load_first  = din[WIDTH-1];
      load_rest   = din << 1;
      next_bit    = shreg[WIDTH-1];
      shreg_shift = shreg << 1;
    end else begin
      load_first  = din[0];
      load_rest   = din >> 1;
      next_bit    = shreg[0];
      shreg_shift = shreg >> 1;
    end
  end

  // Ready depends only on state and count; reset low blocks any accept.
  always_comb begin
    last_bit  = (state == SHIFT) && (cnt == LAST_IDX);
    din_ready = reset && ((state == IDLE) || last_bit);
    accept    = din_valid && din_ready;
    cnt_inc   = cnt + CNT_ONE;
  end

  // Next-state and next-output logic; outputs default to the idle line.
  always_comb begin
    state_d      = state;
    shreg_d      = shreg;
    cnt_d        = cnt;
    x_out_d      = IDLE_LEVEL;
    x_valid_d    = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
`ifdef SER_PARITY_EN
    parity_d     = parity_q;
`endif
    if (accept) begin
      // Covers both a fresh start from IDLE and the zero-gap reload on the
      // final bit of the previous frame.
      state_d   = SHIFT;
      shreg_d   = load_rest;
      cnt_d     = '0;
      x_out_d   = load_first;
      x_valid_d = 1'b1;
      busy_d    = 1'b1;
`ifdef SER_PARITY_EN
      parity_d  = ^din;
`endif
    end else begin
      case (state)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (last_bit) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d        = cnt_inc;
            x_valid_d    = 1'b1;
            busy_d       = 1'b1;
            frame_done_d = (cnt_inc == LAST_IDX);
`ifdef SER_PARITY_EN
            if (cnt == LAST_DATA) begin
              x_out_d = parity_q;
            end else begin
              x_out_d = next_bit;
              shreg_d = shreg_shift;
            end
`else
            x_out_d = next_bit;
            shreg_d = shreg_shift;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      x_out      <= IDLE_LEVEL;
      x_valid    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      cnt        <= cnt_d;
      x_out      <= x_out_d;
      x_valid    <= x_valid_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
`ifdef SER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: scoreboard on the default instance, directed
// sequence on an LSB-first instance, idle watch on an IDLE_LEVEL=1 instance.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FL = W + 1;
  localparam int Y_EXP = 3;
`else
  localparam int FL = W;
  localparam int Y_EXP = 5;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid, din_ready, x_out, x_valid, busy, frame_done;
  logic [W-1:0] l_din;
  logic         l_valid, l_ready, l_x, l_xv, l_busy, l_fd;
  logic [W-1:0] i_din;
  logic         i_valid, i_ready, i_x, i_xv, i_busy, i_fd;

  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t e;
  int   run_len = 0;
  int   y_cnt = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x_out(x_out), .x_valid(x_valid),
    .busy(busy), .frame_done(frame_done));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(l_din), .din_valid(l_valid),
    .din_ready(l_ready), .x_out(l_x), .x_valid(l_xv),
    .busy(l_busy), .frame_done(l_fd));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_idle (
    .clk(clk), .reset(reset), .din(i_din), .din_valid(i_valid),
    .din_ready(i_ready), .x_out(i_x), .x_valid(i_xv),
    .busy(i_busy), .frame_done(i_fd));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pop one expected bit per valid cycle, push on accept.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("x_valid", {31'd0, x_valid}, 32'd1);
        chk("x_out", {31'd0, x_out}, {31'd0, e.b});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e.last});
        chk("busy", {31'd0, busy}, 32'd1);
        chk("din_ready_busy", {31'd0, din_ready}, {31'd0, reset & e.last});
      end else begin
        chk("idle_x_valid", {31'd0, x_valid}, 32'd0);
        chk("idle_x_out", {31'd0, x_out}, 32'd0);
        chk("idle_frame_done", {31'd0, frame_done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("din_ready_idle", {31'd0, din_ready}, {31'd0, reset});
      end
      chk("idle1_x_out", {31'd0, i_x}, 32'd1);
      chk("idle1_x_valid", {31'd0, i_xv}, 32'd0);
      chk("idle1_ready", {31'd0, i_ready}, {31'd0, reset});
      chk("idle1_frame_done", {31'd0, i_fd}, 32'd0);
      if (x_valid === 1'b1 && x_out === 1'b1) run_len++;
      else run_len = 0;
      if (run_len >= 3) y_cnt++;
      if (!reset) begin
        sb.delete();
      end else if (din_valid && din_ready) begin
        for (int i = 0; i < W; i++)
          sb.push_back('{b: din[W-1-i], last: (FL == W) && (i == W - 1)});
`ifdef SER_PARITY_EN
        sb.push_back('{b: ^din, last: 1'b1});
`endif
      end
    end
  end

  // Present a word and wait (bounded) for it to be accepted.
  task automatic send(input logic [W-1:0] w, input bit keep_valid);
    bit acc;
    acc = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #2;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    if (!keep_valid) din_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] lw;
    int pos;
    logic eb;
    reset = 1'b0;
    din = '0; din_valid = 1'b0;
    l_din = '0; l_valid = 1'b0;
    i_din = '0; i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 mon_en = 1'b1;
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2;

    send(8'hB4, 1'b0);
    repeat (12) @(posedge clk); #2;

    y_cnt = 0;
    send(8'h0F, 1'b1);
    send(8'hE0, 1'b0);
    repeat (14) @(posedge clk); #2;
    chk("y_run_cycles", y_cnt, Y_EXP);

    send(8'h07, 1'b0);
    repeat (12) @(posedge clk); #2;

    // Abort an all-ones frame after its fourth bit.
    y_cnt = 0;
    send(8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    repeat (12) @(posedge clk); #2;
    chk("ones_after_abort", y_cnt, 2);
    send(8'h5A, 1'b0);
    repeat (12) @(posedge clk); #2;

    // LSB-first: 01 then FF offered mid-frame, taken only in the ready window.
    l_din = 8'h01; l_valid = 1'b1;
    for (int c = 1; c <= 2 * FL; c++) begin
      @(posedge clk); #2;
      if (c == 1) l_valid = 1'b0;
      if (c == 3) begin l_din = 8'hFF; l_valid = 1'b1; end
      if (c == FL + 1) l_valid = 1'b0;
      @(negedge clk);
      pos = (c - 1) % FL;
      lw = (c <= FL) ? 8'h01 : 8'hFF;
      eb = (pos < W) ? lw[pos] : ^lw;
      chk("lsb_x_valid", {31'd0, l_xv}, 32'd1);
      chk("lsb_x_out", {31'd0, l_x}, {31'd0, eb});
      chk("lsb_ready", {31'd0, l_ready}, {31'd0, pos == FL - 1});
      chk("lsb_frame_done", {31'd0, l_fd}, {31'd0, pos == FL - 1});
    end
    @(negedge clk);
    chk("lsb_end_x_valid", {31'd0, l_xv}, 32'd0);
    chk("lsb_end_busy", {31'd0, l_busy}, 32'd0);

    repeat (4) @(posedge clk); #2;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial converter that feeds the downstream three-consecutive-ones run detector's serial input `x`, one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB- or LSB-first.
- Back-to-back words stream with no gap, so bit runs can span word boundaries.
- Between words the line is driven to IDLE_LEVEL; with the default of 0 the detector sees no spurious run.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
- IDLE_LEVEL, 0, value driven on x_out whenever x_valid = 0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- din  input  WIDTH  parallel word to transmit
- din_valid  input  1  din holds a word to transmit
- din_ready  output  1  block can accept a word this cycle
- x_out  output  1  serial bit stream (connects to the detector's x)
- x_valid  output  1  x_out carries a data bit (or a parity bit) this cycle
- busy  output  1  a frame is in progress
- frame_done  output  1  one-cycle pulse on the cycle the last bit of a frame is on x_out

Behaviour:
- Reset (reset low at a rising clk edge):
  - state = IDLE, x_out = IDLE_LEVEL, x_valid = 0, busy = 0, frame_done = 0.
  - Shift register and bit counter are cleared.
  - din_ready is forced to 0 while reset is low; no word is accepted.
- Accept condition: din_valid && din_ready at a rising edge. The word is captured and its first bit appears on x_out, with x_valid = 1, in the next cycle. Latency from accept to first bit is 1 cycle.
- x_out, x_valid, busy and frame_done are registered. din_ready is combinational from state and bit count only; it never depends on din_valid.
- States:
  - IDLE: din_ready = 1, x_valid = 0, x_out = IDLE_LEVEL. On accept -> SHIFT with bit count 0.
  - SHIFT: x_valid = 1, busy = 1. x_out = current bit; the bit count advances every cycle.
    - din_ready = 1 only while the final bit (count = WIDTH-1) is on x_out.
    - On the final-bit cycle with accept: reload the shift register, count = 0, stay in SHIFT. The next word's first bit follows with zero gap.
    - On the final-bit cycle without accept: -> IDLE. In the next cycle x_valid = 0 and x_out = IDLE_LEVEL.
- frame_done is high exactly on the cycle the final bit of a frame is presented, including the back-to-back case.
- din_valid high while din_ready = 0 (mid-frame): nothing is captured and din is ignored. The upstream must hold din until it is accepted.
- din changing mid-frame does not affect the frame in flight; the word is snapshotted at accept.
- Reset low mid-frame: the frame is aborted at that edge, the partial word is discarded and all outputs take their reset values. No further bits of that word are sent.
- Bit counter width is clog2(WIDTH+1) and it never wraps past the frame length.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit is sent: the even parity (XOR of the captured word), with x_valid = 1. Frame length is WIDTH+1.
  - din_ready and frame_done move from the last data bit to the parity-bit cycle.
  - Back-to-back reload happens on the parity cycle.
- Undefined: there is no parity bit and the frame length is WIDTH. The parity logic is absent from the netlist.

Test Plan:
- WIDTH=8, MSB_FIRST=1: accept 8'hB4 at cycle 0.
  - Required: x_out = 1,0,1,1,0,1,0,0 on cycles 1..8 with x_valid = 1.
  - Required: frame_done pulses only at cycle 8.
  - Required: cycle 9 has x_valid = 0, x_out = 0, busy = 0.
- Back-to-back 8'h0F then 8'hE0, with din_valid held high.
  - Required: 16 consecutive valid bits 0000_1111_1110_0000 with no gap, and frame_done at cycles 8 and 16.
  - Required: the run of seven ones across the word boundary makes the downstream detector's y high for 5 cycles.
- MSB_FIRST=0: accept 8'h01.
  - Required: x_out = 1,0,0,0,0,0,0,0.
  - Required: din_valid asserted at cycle 3 with din = 8'hFF is not accepted until the cycle-8 ready window.
- Reset low at cycle 4 of an 8'hFF frame.
  - Required: from cycle 5, x_valid = 0, x_out = IDLE_LEVEL, busy = 0, with no further ones.
  - Required: after reset is released, the next accept starts a fresh frame at bit 0.
- SER_PARITY_EN defined:
  - 8'hB4 -> 9 bits ending in parity 0.
  - 8'h07 -> parity 1.
  - frame_done is on bit 9; din_ready is high only on the parity cycle.
- IDLE_LEVEL=1 with no traffic after reset: x_out = 1, x_valid = 0 and din_ready = 1 indefinitely, and frame_done never pulses.
